instr_fetch_ctrl: RTL and testbench

- Fetch sequencer for the combinational, word-addressed instruction ROM: owns the PC, drives the ROM byte address and captures each returned opcode.
- Buffers fetched {pc, instr} pairs in a small FIFO, offered to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush plus new PC) and range/alignment faults.
- Sits between the instruction ROM and the decode stage of the single-issue RV32I core.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_buffer.sv | 67 ++++++
 rtl/instr_fetch_ctrl.sv | 108 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   fetch_entry_t  : one buffered fetch, {pc, instr}
//   fetch_state_t  : sequencer state (RUN fetching, FAULT stopped)
//   INSTR_BYTES    : byte stride between consecutive instructions
//   ROM_LAST_ADDR  : highest legal byte address for a ROM of a given depth
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        RUN,
        FAULT
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

    function automatic logic [31:0] ROM_LAST_ADDR(input int unsigned rom_depth);
        return 32'(rom_depth * INSTR_BYTES - INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetch_entry_t between the PC sequencer and decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, wdata: write an entry at the tail
//   pop        : drop the head entry
//   flush      : discard all entries (wins over push/pop)
//   head       : registered head entry (stale but harmless when empty)
//   full, empty: occupancy flags
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(BUF_DEPTH);

    fetch_entry_t     mem [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_MAX);
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // When full, push is only issued together with pop, so writing the
            // slot under rd_ptr is safe: that entry leaves at this same edge.
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a combinational, word-addressed instruction ROM.
//   clk, rst_n          : clock, asynchronous active-low reset
//   fetch_en            : enable fetching (buffer still drains when low)
//   instr_rAddr         : ROM byte address (current pc)
//   instr_opcode        : ROM data for instr_rAddr, same cycle
//   redirect_valid/_pc  : one-cycle branch/jump redirect request
//   if_valid/if_ready   : handshake towards decode
//   if_instr/if_pc      : buffer head entry
//   fault/fault_pc      : fetch stopped on a bad pc, and which pc
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_DEPTH = 64,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] instr_rAddr,
    input  logic [31:0] instr_opcode,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam logic [31:0] LAST_ADDR = ROM_LAST_ADDR(ROM_DEPTH);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fault_pc_q, fault_pc_d;

    logic         push, pop;
    logic         buf_full, buf_empty;
    logic         redirect_ok, pc_ok;
    fetch_entry_t wdata, head;

    assign redirect_ok = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_ADDR);
    // pc is always word-aligned (reset and accepted redirects are), so only range matters.
    assign pc_ok       = (pc_q <= LAST_ADDR);
    assign wdata       = '{pc: pc_q, instr: instr_opcode};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        push       = 1'b0;
        // A redirect kills the head transfer in the same cycle.
        pop        = !buf_empty && if_ready && !redirect_valid;

        if (redirect_valid) begin
            if (redirect_ok) begin
                pc_d    = redirect_pc;
                state_d = RUN;
            end else begin
                state_d    = FAULT;
                fault_pc_d = redirect_pc;
            end
        end else if (state_q == RUN && fetch_en) begin
            if (!pc_ok) begin
                state_d    = FAULT;
                fault_pc_d = pc_q;
            end else if (!buf_full || pop) begin
                push = 1'b1;
                pc_d = pc_q + 32'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_buffer #(
        .BUF_DEPTH(BUF_DEPTH)
    ) u_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .head  (head),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign instr_rAddr = pc_q;
    assign if_valid    = !buf_empty;
    assign if_instr    = head.instr;
    assign if_pc       = head.pc;
    assign fault       = (state_q == FAULT);
    assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_instr_fetch_ctrl;

    localparam logic [31:0] LAST = 32'h0000_00FC;
    localparam int          BUFN = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] instr_rAddr;
    logic [31:0] instr_opcode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fault;
    logic [31:0] fault_pc;

    logic [31:0] rom [64];

    always #5 clk = ~clk;

    assign instr_opcode = (instr_rAddr <= LAST) ? rom[instr_rAddr[7:2]] : 32'hDEAD_BEEF;

    instr_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .instr_rAddr    (instr_rAddr),
        .instr_opcode   (instr_opcode),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    // Reference model: architectural pc, fault status and the list of
    // fetched-but-not-consumed instructions.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq [$];
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] m_fpc;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'h0;
        m_fault = 1'b0;
        m_fpc   = 32'h0;
    endtask

    task automatic model_step(input logic fe, input logic rv, input logic [31:0] rpc,
                              input logic rdy);
        int   had;
        logic popped;
        if (rv) begin
            mq.delete();
            if (rpc % 4 == 0 && rpc <= LAST) begin
                m_pc    = rpc;
                m_fault = 1'b0;
            end else begin
                m_fault = 1'b1;
                m_fpc   = rpc;
            end
        end else begin
            had    = mq.size();
            popped = (had > 0) && rdy;
            if (popped) void'(mq.pop_front());
            if (!m_fault && fe) begin
                if (m_pc > LAST) begin
                    m_fault = 1'b1;
                    m_fpc   = m_pc;
                end else if (had < BUFN || popped) begin
                    mq.push_back('{pc: m_pc, instr: rom[m_pc / 4]});
                    m_pc = m_pc + 4;
                end
            end
        end
    endtask

    task automatic check_all();
        check32("rAddr", instr_rAddr, m_pc);
        check32("if_valid", {31'b0, if_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            check32("if_pc", if_pc, mq[0].pc);
            check32("if_instr", if_instr, mq[0].instr);
        end
        check32("fault", {31'b0, fault}, {31'b0, m_fault});
        if (m_fault) check32("fault_pc", fault_pc, m_fpc);
    endtask

    // Drive one cycle of inputs, advance the model, sample at the next negedge.
    task automatic step(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        model_step(fe, rv, rpc, rdy);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_valid"}, {31'b0, if_valid}, 32'h0);
        check32({tag, "_instr"}, if_instr, 32'h0);
        check32({tag, "_pc"}, if_pc, 32'h0);
        check32({tag, "_fault"}, {31'b0, fault}, 32'h0);
        check32({tag, "_fault_pc"}, fault_pc, 32'h0);
        check32({tag, "_rAddr"}, instr_rAddr, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0] = 32'h0041_82B3;
        rom[1] = 32'h4041_82B3;
        rom[2] = 32'h0041_92B3;
        rom[3] = 32'h0041_A2B3;
        rom[4] = 32'h0041_B2B3;
        rom[5] = 32'h0041_C2B3;
        rom[6] = 32'h0041_D2B3;
        rom[7] = 32'h4041_D2B3;
        rom[8] = 32'h0041_E2B3;
        rom[9] = 32'h0041_F2B3;

        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        model_reset();
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fetch with decode always ready.
        step(1, 0, 0, 1);
        check32("first_pc", if_pc, 32'h0);
        check32("first_instr", if_instr, 32'h0041_82B3);
        for (int k = 2; k <= 10; k++) begin
            step(1, 0, 0, 1);
            check32("seq_valid", {31'b0, if_valid}, 32'h1);
            check32("seq_pc", if_pc, 32'(4 * (k - 1)));
        end
        check32("pc36_instr", if_instr, 32'h0041_F2B3);

        // Backpressure: buffer saturates, pc holds at 8.
        step(1, 1, 32'h0, 1);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0);
        check32("bp_rAddr", instr_rAddr, 32'h8);
        check32("bp_head", if_pc, 32'h0);
        step(1, 0, 0, 1);
        check32("bp_pc4", if_pc, 32'h4);
        step(1, 0, 0, 1);
        check32("bp_pc8", if_pc, 32'h8);
        step(1, 0, 0, 1);
        check32("bp_pc12", if_pc, 32'hC);

        // Redirect with a full buffer holding pc 4 and 8.
        step(1, 1, 32'h4, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check32("rd_pre_head", if_pc, 32'h4);
        step(1, 1, 32'h20, 1);
        check32("rd_flush_valid", {31'b0, if_valid}, 32'h0);
        step(1, 0, 0, 1);
        check32("rd_target_pc", if_pc, 32'h20);

        // Misaligned redirect faults; a good redirect recovers.
        step(1, 1, 32'h22, 1);
        check32("mis_fault", {31'b0, fault}, 32'h1);
        check32("mis_fault_pc", fault_pc, 32'h22);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 1);
            check32("mis_nopush", {31'b0, if_valid}, 32'h0);
        end
        step(1, 1, 32'h10, 1);
        check32("mis_clear", {31'b0, fault}, 32'h0);
        step(1, 0, 0, 1);
        check32("mis_recover_pc", if_pc, 32'h10);

        // Sequential overrun at the end of the ROM.
        step(1, 1, 32'hF0, 1);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 1);
        check32("end_last_pc", if_pc, 32'hFC);
        step(1, 0, 0, 1);
        check32("end_fault", {31'b0, fault}, 32'h1);
        check32("end_fault_pc", fault_pc, 32'h100);
        check32("end_drained", {31'b0, if_valid}, 32'h0);

        // Asynchronous reset in the middle of a full buffer.
        step(1, 1, 32'h0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check32("ar_full_valid", {31'b0, if_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        redirect_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 1);
        check32("ar_restart_pc", if_pc, 32'h0);
        check32("ar_restart_instr", if_instr, 32'h0041_82B3);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic        fe, rv, rdy;
            logic [31:0] rpc;
            fe  = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 6);
            rv  = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 4))
                0, 1: rpc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                2:    rpc = {24'h0, 6'($urandom_range(56, 63)), 2'b00};
                3:    rpc = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                default: rpc = 32'h100 + 32'($urandom_range(0, 255)) * 4;
            endcase
            step(fe, rv, rpc, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
